// File: rtl/lzma_stream_framer.sv
// Frames each compressed LZMA byte stream with the 13-byte .lzma header and
// presents it on a ready/valid/last master port, buffering payload in a FIFO.
module lzma_stream_framer #(
  parameter logic [31:0] DICT_SIZE = 32'h00001000,
  parameter logic [7:0]  PROPS     = 8'h5D,
  parameter int unsigned FIFO_AW   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_end,
  input  logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW+1:0] DEPTH_W = (FIFO_AW+2)'(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  logic [7:0]         stage_q;
  logic               stage_vld_q;
  logic [8:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, rd_q, wr_d, rd_d, wr1;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [FIFO_AW+1:0] free_w;
  state_t             state_q;
  logic [3:0]         idx_q;

  logic       push0, push1, acc0, acc1, stage_ld, stage_clr;
  logic [8:0] push0_d, push1_d, head;
  logic       empty, take, pop;

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return PROPS;
      4'd1:    return DICT_SIZE[7:0];
      4'd2:    return DICT_SIZE[15:8];
      4'd3:    return DICT_SIZE[23:16];
      4'd4:    return DICT_SIZE[31:24];
      default: return 8'hFF;
    endcase
  endfunction

  // An end marker may flush the staged byte and the incoming byte at once,
  // hence the two write slots.
  always_comb begin
    push0     = 1'b0;
    push1     = 1'b0;
    push0_d   = '0;
    push1_d   = '0;
    stage_ld  = 1'b0;
    stage_clr = 1'b0;
    if (i_end && (stage_vld_q || i_valid)) begin
      stage_clr = 1'b1;
      push0     = 1'b1;
      if (stage_vld_q && i_valid) begin
        push0_d = {1'b0, stage_q};
        push1   = 1'b1;
        push1_d = {1'b1, i_data};
      end else if (stage_vld_q) begin
        push0_d = {1'b1, stage_q};
      end else begin
        push0_d = {1'b1, i_data};
      end
    end else if (i_valid) begin
      stage_ld = 1'b1;
      push0    = stage_vld_q;
      push0_d  = {1'b0, stage_q};
    end
  end

  assign empty  = (count_q == '0);
  assign head   = mem_q[rd_q];
  assign take   = !o_valid || o_ready;
  assign pop    = take && (state_q == BODY) && !empty;
  assign free_w = DEPTH_W - {1'b0, count_q} + (FIFO_AW+2)'(pop);
  assign acc0   = push0 && (free_w != '0);
  assign acc1   = push1 && (free_w >= (FIFO_AW+2)'(2));
  assign wr1    = wr_q + FIFO_AW'(1);
  assign wr_d   = wr_q + FIFO_AW'(acc0) + FIFO_AW'(acc1);
  assign rd_d   = rd_q + FIFO_AW'(pop);
  assign count_d = count_q + (FIFO_AW+1)'(acc0) + (FIFO_AW+1)'(acc1)
                 - (FIFO_AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (acc0) mem_q[wr_q] <= push0_d;
    if (acc1) mem_q[wr1]  <= push1_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      overflow    <= 1'b0;
    end else begin
      if (stage_clr) begin
        stage_vld_q <= 1'b0;
      end else if (stage_ld) begin
        stage_q     <= i_data;
        stage_vld_q <= 1'b1;
      end
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if ((push0 && !acc0) || (push1 && !acc1)) overflow <= 1'b1;
    end
  end

  // The output register is reloaded only when empty or being accepted, so a
  // stalled beat holds; IDLE issues header byte 0 directly to save a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (take) begin
      case (state_q)
        IDLE: begin
          o_last <= 1'b0;
          if (!empty || stage_vld_q) begin
            o_valid <= 1'b1;
            o_data  <= hdr_byte(4'd0);
            idx_q   <= 4'd1;
            state_q <= HDR;
          end else begin
            o_valid <= 1'b0;
          end
        end
        HDR: begin
          o_valid <= 1'b1;
          o_last  <= 1'b0;
          o_data  <= hdr_byte(idx_q);
          if (idx_q == 4'd12) begin
            idx_q   <= '0;
            state_q <= BODY;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        BODY: begin
          if (!empty) begin
            o_valid <= 1'b1;
            o_data  <= head[7:0];
            o_last  <= head[8];
            if (head[8]) state_q <= IDLE;
          end else begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lzma_stream_framer.sv
// Self-checking bench for lzma_stream_framer: directed framing cases plus
// randomized streams against a queue-based model of the framed output.
module tb_lzma_stream_framer;

  localparam logic [31:0] DICT = 32'h00001000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, i_valid, i_end, o_ready, o_valid, o_last, overflow;
  logic [7:0] i_data, o_data;
  logic       s_rst, s_valid, s_end, s_ready, s_ovalid, s_olast, s_ovf;
  logic [7:0] s_data, s_odata;

  lzma_stream_framer dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_end(i_end),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
    .overflow(overflow)
  );

  lzma_stream_framer #(.FIFO_AW(2)) dut_s (
    .clk(clk), .rst(s_rst), .i_valid(s_valid), .i_data(s_data), .i_end(s_end),
    .o_ready(s_ready), .o_valid(s_ovalid), .o_data(s_odata), .o_last(s_olast),
    .overflow(s_ovf)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] expq[$];
  logic [8:0] sq[$];
  int         beats = 0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_beat;
  int         rdy_mode = 1;
  int         rdy_ph = 0;
  bit         s_collect = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hdr_ref(input int k);
    if (k == 0) return 8'h5D;
    if (k <= 4) return 8'(DICT >> (8 * (k - 1)));
    return 8'hFF;
  endfunction

  // Entered at a falling edge; samples one unit before the rising edge.
  task automatic step();
    case (rdy_mode)
      0: o_ready = ($urandom_range(0, 3) != 0);
      1: o_ready = 1'b1;
      default: begin
        o_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
        rdy_ph++;
      end
    endcase
    #4;
    if (prev_stall) check("stall_hold", 32'({o_valid, o_last, o_data}), 32'({1'b1, prev_beat}));
    if (o_valid && o_ready) begin
      beats++;
      if (expq.size() == 0) check("unexpected_beat", 32'(expq.size()), 32'd1);
      else check("beat", 32'({o_last, o_data}), 32'(expq.pop_front()));
    end
    prev_stall = o_valid && !o_ready;
    prev_beat  = {o_last, o_data};
    if (s_collect && s_ovalid && s_ready) sq.push_back({s_olast, s_odata});
    @(negedge clk);
  endtask

  task automatic expect_stream(input logic [7:0] b[$]);
    for (int k = 0; k < 13; k++) expq.push_back({1'b0, hdr_ref(k)});
    for (int k = 0; k < b.size(); k++) expq.push_back({k == b.size() - 1, b[k]});
  endtask

  task automatic feed(input logic [7:0] b[$], input bit end_sep, input int max_gap);
    expect_stream(b);
    for (int k = 0; k < b.size(); k++) begin
      i_valid = 1'b1;
      i_data  = b[k];
      i_end   = (k == b.size() - 1) && !end_sep;
      step();
      i_valid = 1'b0;
      i_end   = 1'b0;
      if (k != b.size() - 1) repeat ($urandom_range(0, max_gap)) step();
    end
    if (end_sep) begin
      repeat ($urandom_range(0, max_gap)) step();
      i_end = 1'b1;
      step();
      i_end = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && expq.size() != 0; c++) step();
    check("drain_left", 32'(expq.size()), 32'd0);
    repeat (6) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] qq[$];
    int b0;
    logic [8:0] e;

    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_end = 1'b0; o_ready = 1'b1;
    s_rst = 1'b1; s_valid = 1'b0; s_data = '0; s_end = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_last", 32'(o_last), 0);
    check("rst_ovf", 32'(overflow), 0);
    step();
    rst = 1'b0;
    s_rst = 1'b0;
    step();

    // Single stream, end coincident with last byte
    rdy_mode = 1;
    b0 = beats;
    q = {8'h11, 8'h22, 8'h33};
    feed(q, 1'b0, 0);
    drain(200);
    check("t1_beats", 32'(beats - b0), 32'd16);
    check("t1_ovf", 32'(overflow), 0);

    // End one cycle after last byte, then a lone end that frames nothing
    b0 = beats;
    q = {8'hA0, 8'hA1};
    feed(q, 1'b1, 0);
    i_end = 1'b1;
    step();
    i_end = 1'b0;
    drain(200);
    check("t2_beats", 32'(beats - b0), 32'd15);

    // Sink ready pattern 1,0,0,1
    rdy_mode = 2;
    rdy_ph = 0;
    b0 = beats;
    q = {8'h11, 8'h22, 8'h33};
    feed(q, 1'b0, 0);
    drain(400);
    check("t3_beats", 32'(beats - b0), 32'd16);

    // Back-to-back streams
    rdy_mode = 1;
    b0 = beats;
    q = {8'h01, 8'h02};
    feed(q, 1'b0, 0);
    q = {8'h03};
    feed(q, 1'b0, 0);
    drain(300);
    check("t4_beats", 32'(beats - b0), 32'd29);

    // Randomized streams, gaps, end placement and sink readiness
    rdy_mode = 0;
    for (int s = 0; s < 30; s++) begin
      q.delete();
      repeat ($urandom_range(1, 10)) q.push_back(8'($urandom));
      feed(q, 1'($urandom_range(0, 1)), 2);
      if ($urandom_range(0, 3) == 0) begin
        i_end = 1'b1;
        step();
        i_end = 1'b0;
      end
      repeat ($urandom_range(0, 3)) step();
    end
    drain(3000);
    check("rand_ovf", 32'(overflow), 0);

    // Overflow on the 4-entry instance with a stalled sink
    rdy_mode = 1;
    s_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h40 + k);
      step();
    end
    s_valid = 1'b0;
    check("ovf_set", 32'(s_ovf), 1);
    repeat (5) step();
    check("ovf_sticky", 32'(s_ovf), 1);
    s_ready = 1'b1;
    s_collect = 1'b1;
    repeat (25) step();
    s_end = 1'b1;
    step();
    s_end = 1'b0;
    repeat (10) step();
    s_collect = 1'b0;
    check("ovf_beats", 32'(sq.size()), 32'd18);
    for (int i = 0; i < sq.size() && i < 18; i++) begin
      if (i < 13) e = {1'b0, hdr_ref(i)};
      else if (i < 17) e = {1'b0, 8'(8'h40 + i - 13)};
      else e = {1'b1, 8'h49};
      check("ovf_beat", 32'(sq[i]), 32'(e));
    end
    check("ovf_still", 32'(s_ovf), 1);

    // Reset while header byte 6 is being presented
    b0 = beats;
    qq.delete();
    expect_stream(qq);
    void'(expq.pop_back());
    q = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
    for (int k = 0; k < q.size(); k++) begin
      i_valid = 1'b1;
      i_data  = q[k];
      step();
    end
    i_valid = 1'b0;
    for (int c = 0; c < 50 && (beats - b0) < 6; c++) step();
    check("rst_at_idx", 32'(beats - b0), 32'd6);
    check("pre_rst_data", 32'(o_data), 32'(hdr_ref(6)));
    rst = 1'b1;
    s_rst = 1'b1;
    #1;
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_ovf", 32'(overflow), 0);
    check("midrst_s_ovf", 32'(s_ovf), 0);
    check("midrst_s_valid", 32'(s_ovalid), 0);
    expq.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    s_rst = 1'b0;
    step();
    check("post_rst_valid", 32'(o_valid), 0);
    b0 = beats;
    q = {8'hD0, 8'hD1};
    feed(q, 1'b0, 1);
    drain(200);
    check("t7_beats", 32'(beats - b0), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
